ntt_addrgen_unified: RTL and testbench

Parametrised butterfly address and twiddle-index generator for both forward NTT and inverse NTT over an N = 2^LOGN point polynomial. It is selected per run by a mode input. It sits between the transform controller and the coefficient RAM / zeta ROM. It emits one butterfly address pair plus zeta index per beat, under a valid/ready handshake, so downstream pipeline stalls are absorbed without loss.

---
 rtl/ntt_addrgen_unified.sv | 166 ++++++++++++++++
 tb/tb_ntt_addrgen_unified.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_addrgen_unified.sv
// Butterfly address pair and zeta index generator for forward NTT / INTT over N = 2^LOGN.
// Latency: first beat valid one cycle after i_start is taken in IDLE, then one beat per cycle.
// Backpressure: payload registered and held while o_valid && !i_ready; counters step only on acceptance.
`timescale 1ns/1ps
module ntt_addrgen_unified #(
  parameter int LOGN = 8,
  parameter int ZW   = LOGN - 1,
  parameter int SW   = $clog2(LOGN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_start,
  input  logic            i_mode,
  input  logic            i_ready,
  output logic            o_valid,
  output logic [LOGN-1:0] o_addr_up,
  output logic [LOGN-1:0] o_addr_dn,
  output logic [ZW-1:0]   o_zeta_idx,
  output logic [SW-1:0]   o_stage,
  output logic            o_first_stage,
  output logic            o_last_stage,
  output logic            o_busy,
  output logic            o_done
);

  // One spare bit so start + 2*len can reach N without wrapping.
  localparam int AW = LOGN + 1;
  localparam logic [AW-1:0] N_FULL     = AW'(1) << LOGN;
  localparam logic [AW-1:0] N_HALF     = AW'(1) << (LOGN - 1);
  localparam logic [AW-1:0] LEN_TWO    = AW'(2);
  localparam logic [ZW-1:0] K_FWD0     = ZW'(1);
  localparam logic [ZW-1:0] K_INV0     = ZW'((1 << (LOGN - 1)) - 1);
  localparam logic [SW-1:0] LAST_STAGE = SW'(LOGN - 2);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t        state;
  logic          mode;
  logic [AW-1:0] len;
  logic [AW-1:0] start;
  logic [AW-1:0] j;
  logic [ZW-1:0] k;
  logic [SW-1:0] stage;

  logic [AW-1:0]   grp_last;
  logic [AW-1:0]   next_grp;
  logic            grp_end;
  logic            stage_end;
  logic            final_beat;
  logic [AW-1:0]   n_len;
  logic [AW-1:0]   n_start;
  logic [AW-1:0]   n_j;
  logic [ZW-1:0]   n_k;
  logic [SW-1:0]   n_stage;
  logic [LOGN-1:0] n_dn;
  logic [AW-1:0]   init_len;
  logic [ZW-1:0]   init_k;
  logic            accept;

  assign accept   = o_valid && i_ready;
  assign init_len = i_mode ? LEN_TWO : N_HALF;
  assign init_k   = i_mode ? K_INV0 : K_FWD0;

  // Next-beat counter values: step j inside a group, jump to the next group, or roll to the next stage.
  always_comb begin
    grp_last   = start + len - AW'(1);
    next_grp   = start + (len << 1);
    grp_end    = (j == grp_last);
    stage_end  = grp_end && (next_grp >= N_FULL);
    final_beat = stage_end && (stage == LAST_STAGE);
    n_len      = len;
    n_start    = start;
    n_j        = j + AW'(1);
    n_k        = k;
    n_stage    = stage;
    if (grp_end) begin
      n_k = mode ? (k - ZW'(1)) : (k + ZW'(1));
      if (stage_end) begin
        n_start = '0;
        n_j     = '0;
        n_len   = mode ? (len << 1) : (len >> 1);
        n_stage = stage + SW'(1);
      end else begin
        n_start = next_grp;
        n_j     = next_grp;
      end
    end
    // Within a stage j + len <= N-1, so the truncated sum is exact.
    n_dn = n_j[LOGN-1:0] + n_len[LOGN-1:0];
  end

  // Control FSM with counters and registered beat payload; outputs are zero whenever idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      mode          <= 1'b0;
      len           <= '0;
      start         <= '0;
      j             <= '0;
      k             <= '0;
      stage         <= '0;
      o_valid       <= 1'b0;
      o_addr_up     <= '0;
      o_addr_dn     <= '0;
      o_zeta_idx    <= '0;
      o_stage       <= '0;
      o_first_stage <= 1'b0;
      o_last_stage  <= 1'b0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
    end else begin
      o_done <= 1'b0;
      if (state == S_IDLE) begin
        if (i_start) begin
          state         <= S_RUN;
          mode          <= i_mode;
          len           <= init_len;
          start         <= '0;
          j             <= '0;
          k             <= init_k;
          stage         <= '0;
          o_valid       <= 1'b1;
          o_busy        <= 1'b1;
          o_addr_up     <= '0;
          o_addr_dn     <= init_len[LOGN-1:0];
          o_zeta_idx    <= init_k;
          o_stage       <= '0;
          o_first_stage <= 1'b1;
          o_last_stage  <= (LAST_STAGE == SW'(0));
        end
      end else if (accept) begin
        if (final_beat) begin
          state         <= S_IDLE;
          mode          <= 1'b0;
          len           <= '0;
          start         <= '0;
          j             <= '0;
          k             <= '0;
          stage         <= '0;
          o_valid       <= 1'b0;
          o_busy        <= 1'b0;
          o_addr_up     <= '0;
          o_addr_dn     <= '0;
          o_zeta_idx    <= '0;
          o_stage       <= '0;
          o_first_stage <= 1'b0;
          o_last_stage  <= 1'b0;
          o_done        <= 1'b1;
        end else begin
          len           <= n_len;
          start         <= n_start;
          j             <= n_j;
          k             <= n_k;
          stage         <= n_stage;
          o_addr_up     <= n_j[LOGN-1:0];
          o_addr_dn     <= n_dn;
          o_zeta_idx    <= n_k;
          o_stage       <= n_stage;
          o_first_stage <= (n_stage == SW'(0));
          o_last_stage  <= (n_stage == LAST_STAGE);
        end
      end
    end
  end

endmodule

// File: tb/tb_ntt_addrgen_unified.sv
// Self-checking bench for ntt_addrgen_unified at LOGN=4 and LOGN=8.
// Expected beats come from a nested-loop model of the transform schedule.
// Covers fixed vectors, stalls, ignored mid-run inputs, back-to-back runs and mid-run reset.
`timescale 1ns/1ps
module tb_ntt_addrgen_unified;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic start4, mode4, ready4, valid4, first4, last4, busy4, done4;
  logic [3:0] up4, dn4;
  logic [2:0] zeta4;
  logic [1:0] stage4;
  logic start8, mode8, ready8, valid8, first8, last8, busy8, done8;
  logic [7:0] up8, dn8;
  logic [6:0] zeta8;
  logic [2:0] stage8;

  ntt_addrgen_unified #(.LOGN(4)) dut4 (
    .clk(clk), .rst(rst), .i_start(start4), .i_mode(mode4), .i_ready(ready4),
    .o_valid(valid4), .o_addr_up(up4), .o_addr_dn(dn4), .o_zeta_idx(zeta4),
    .o_stage(stage4), .o_first_stage(first4), .o_last_stage(last4),
    .o_busy(busy4), .o_done(done4));

  ntt_addrgen_unified #(.LOGN(8)) dut8 (
    .clk(clk), .rst(rst), .i_start(start8), .i_mode(mode8), .i_ready(ready8),
    .o_valid(valid8), .o_addr_up(up8), .o_addr_dn(dn8), .o_zeta_idx(zeta8),
    .o_stage(stage8), .o_first_stage(first8), .o_last_stage(last8),
    .o_busy(busy8), .o_done(done8));

  typedef struct {
    bit valid; int up; int dn; int zeta; int stage; bit first; bit last; bit busy; bit done;
  } smp_t;
  typedef struct { int up; int dn; int zeta; int stage; bit first; bit last; } beat_t;
  typedef struct { bit big; bit md; int beat; int up; int dn; int zeta; int last; } vec_t;

  int checks = 0;
  int failures = 0;
  beat_t cap[$];
  beat_t model_q[$];
  beat_t c4f[$], c4i[$], c8f[$], c8i[$];
  vec_t tbl[10];

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  function automatic smp_t sample(input bit big);
    smp_t s;
    if (big) begin
      s.valid = valid8; s.up = int'(up8); s.dn = int'(dn8); s.zeta = int'(zeta8);
      s.stage = int'(stage8); s.first = first8; s.last = last8; s.busy = busy8; s.done = done8;
    end else begin
      s.valid = valid4; s.up = int'(up4); s.dn = int'(dn4); s.zeta = int'(zeta4);
      s.stage = int'(stage4); s.first = first4; s.last = last4; s.busy = busy4; s.done = done4;
    end
    return s;
  endfunction

  function automatic int any_out(input smp_t s);
    return int'(s.valid | s.busy | s.done | s.first | s.last |
                (s.up != 0) | (s.dn != 0) | (s.zeta != 0) | (s.stage != 0));
  endfunction

  function automatic int same_payload(input smp_t a, input smp_t b);
    return int'(a.valid == b.valid && a.up == b.up && a.dn == b.dn && a.zeta == b.zeta &&
                a.stage == b.stage && a.first == b.first && a.last == b.last);
  endfunction

  function automatic beat_t to_beat(input smp_t s);
    beat_t b;
    b.up = s.up; b.dn = s.dn; b.zeta = s.zeta; b.stage = s.stage; b.first = s.first; b.last = s.last;
    return b;
  endfunction

  function automatic int beat_eq(input beat_t a, input beat_t b);
    return int'(a.up == b.up && a.dn == b.dn && a.zeta == b.zeta &&
                a.stage == b.stage && a.first == b.first && a.last == b.last);
  endfunction

  task automatic drive(input bit big, input bit s, input bit m, input bit r);
    if (big) begin start8 = s; mode8 = m; ready8 = r; end
    else     begin start4 = s; mode4 = m; ready4 = r; end
  endtask

  // Transform schedule written directly as stage / group / butterfly loops.
  function automatic void gen_model(input int logn, input bit md);
    int n, len, k;
    beat_t b;
    n = 1 << logn;
    len = md ? 2 : n / 2;
    k = md ? n / 2 - 1 : 1;
    model_q.delete();
    for (int s = 0; s < logn - 1; s++) begin
      for (int st = 0; st < n; st += 2 * len) begin
        for (int jj = st; jj < st + len; jj++) begin
          b.up = jj; b.dn = jj + len; b.zeta = k; b.stage = s;
          b.first = (s == 0); b.last = (s == logn - 2);
          model_q.push_back(b);
        end
        k = md ? k - 1 : k + 1;
      end
      len = md ? len * 2 : len / 2;
    end
  endfunction

  task automatic check_seq(input string name, input int logn, input bit md);
    int mism, n, bad;
    int seen[];
    gen_model(logn, md);
    chk({name, "_count"}, cap.size(), model_q.size());
    mism = 0;
    for (int i = 0; i < model_q.size(); i++)
      if (i >= cap.size() || beat_eq(cap[i], model_q[i]) == 0) mism++;
    chk({name, "_seq_mismatches"}, mism, 0);
    n = 1 << logn;
    for (int s = 0; s < logn - 1; s++) begin
      seen = new[n];
      foreach (cap[i]) if (cap[i].stage == s) begin
        if (cap[i].up < n) seen[cap[i].up]++;
        if (cap[i].dn < n) seen[cap[i].dn]++;
      end
      bad = 0;
      foreach (seen[a]) if (seen[a] != 1) bad++;
      chk($sformatf("%s_stage%0d_cover", name, s), bad, 0);
    end
  endtask

  // One run: optional random stalls, optional junk on start/mode, optional reset after rst_at beats.
  task automatic run(input bit big, input bit md, input bit stall, input int rst_at, input bit junk);
    smp_t cur, held;
    bit pstall, pacc, fin, r, js, jm;
    int n, total, cyc, sleft;
    pstall = 0; pacc = 0; fin = 0; n = 0; cyc = 0; sleft = 0;
    total = big ? 896 : 24;
    cap.delete();
    @(negedge clk); drive(big, 1'b1, md, 1'b1);
    @(negedge clk); drive(big, 1'b0, md, 1'b1);
    cur = sample(big);
    chk("start_latency_valid", int'(cur.valid), 1);
    while (!fin && cyc < 20000) begin
      cur = sample(big);
      if (pstall) chk("stall_hold", same_payload(cur, held), 1);
      if (pacc && n == total) begin
        chk("done_pulse", int'(cur.done), 1);
        chk("idle_after_last", int'(cur.valid | cur.busy), 0);
        fin = 1;
      end else begin
        if (!cur.valid) chk("valid_during_run", int'(cur.valid), 1);
        if (sleft > 0) begin
          r = 0; sleft--;
        end else begin
          r = 1;
          if (stall && $urandom_range(0, 2) == 0) sleft = $urandom_range(0, 5);
        end
        if (r && cur.valid) begin cap.push_back(to_beat(cur)); n++; end
        pacc = r && cur.valid;
        pstall = !r && cur.valid;
        held = cur;
        js = junk ? 1'($urandom_range(0, 1)) : 1'b0;
        jm = junk ? 1'($urandom_range(0, 1)) : md;
        drive(big, js, jm, r);
        if (rst_at > 0 && n == rst_at && pacc) begin
          #2 rst = 1'b1;
          #1 cur = sample(big);
          chk("async_rst_outputs_zero", any_out(cur), 0);
          drive(big, 1'b0, 1'b0, 1'b1);
          @(negedge clk);
          cur = sample(big);
          chk("rst_no_done", int'(cur.done), 0);
          rst = 1'b0;
          repeat (3) @(negedge clk);
          cur = sample(big);
          chk("post_rst_idle", any_out(cur), 0);
          return;
        end
        @(negedge clk);
        cyc++;
      end
    end
    chk("run_finished", int'(fin), 1);
    drive(big, 1'b0, md, 1'b1);
    @(negedge clk);
    cur = sample(big);
    chk("done_one_cycle", int'(cur.done), 0);
  endtask

  function automatic beat_t pick(input bit big, input bit md, input int idx);
    beat_t b;
    b = '{default: 0};
    if (!big && !md && idx < c4f.size()) b = c4f[idx];
    if (!big &&  md && idx < c4i.size()) b = c4i[idx];
    if ( big && !md && idx < c8f.size()) b = c8f[idx];
    if ( big &&  md && idx < c8i.size()) b = c8i[idx];
    return b;
  endfunction

  function automatic int cap_size(input bit big, input bit md);
    if (!big) return md ? c4i.size() : c4f.size();
    return md ? c8i.size() : c8f.size();
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    smp_t s;
    beat_t b;
    int cnt, mism;
    tbl[0] = '{0, 0,   1,   0,   8,   1, 0};
    tbl[1] = '{0, 0,   9,   0,   4,   2, 0};
    tbl[2] = '{0, 0,  24,  13,  15,   7, 1};
    tbl[3] = '{0, 1,   1,   0,   2,   7, 0};
    tbl[4] = '{0, 1,   3,   4,   6,   6, 0};
    tbl[5] = '{0, 1,  24,   7,  15,   1, 1};
    tbl[6] = '{1, 0,   1,   0, 128,   1, 0};
    tbl[7] = '{1, 0, 896, 253, 255, 127, 1};
    tbl[8] = '{1, 1,   1,   0,   2, 127, 0};
    tbl[9] = '{1, 1, 896, 127, 255,   1, 1};

    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    chk("reset_outputs4", any_out(sample(1'b0)), 0);
    chk("reset_outputs8", any_out(sample(1'b1)), 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_outputs4", any_out(sample(1'b0)), 0);
    chk("idle_outputs8", any_out(sample(1'b1)), 0);

    run(1'b0, 1'b0, 1'b0, 0, 1'b0); check_seq("n4_fwd", 4, 1'b0); c4f = cap;
    run(1'b0, 1'b1, 1'b0, 0, 1'b0); check_seq("n4_inv", 4, 1'b1); c4i = cap;
    run(1'b1, 1'b0, 1'b0, 0, 1'b0); check_seq("n8_fwd", 8, 1'b0); c8f = cap;
    run(1'b1, 1'b1, 1'b0, 0, 1'b0); check_seq("n8_inv", 8, 1'b1); c8i = cap;

    for (int i = 0; i < 10; i++) begin
      chk($sformatf("vec%0d_present", i),
          int'(tbl[i].beat <= cap_size(tbl[i].big, tbl[i].md)), 1);
      b = pick(tbl[i].big, tbl[i].md, tbl[i].beat - 1);
      chk($sformatf("vec%0d_up", i), b.up, tbl[i].up);
      chk($sformatf("vec%0d_dn", i), b.dn, tbl[i].dn);
      chk($sformatf("vec%0d_zeta", i), b.zeta, tbl[i].zeta);
      chk($sformatf("vec%0d_last", i), int'(b.last), tbl[i].last);
    end

    for (int m = 0; m < 2; m++) begin
      run(1'b1, 1'(m), 1'b1, 0, 1'b0);
      check_seq(m ? "n8_inv_stall" : "n8_fwd_stall", 8, 1'(m));
      mism = 0;
      for (int i = 0; i < 896; i++)
        if (i >= cap.size() || beat_eq(cap[i], pick(1'b1, 1'(m), i)) == 0) mism++;
      chk("stall_vs_nostall", mism, 0);
    end

    run(1'b0, 1'b0, 1'b0, 0, 1'b1); check_seq("n4_fwd_junk", 4, 1'b0);
    run(1'b0, 1'b1, 1'b0, 0, 1'b1); check_seq("n4_inv_junk", 4, 1'b1);

    // Back-to-back runs with i_start held high.
    @(negedge clk); drive(1'b0, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    chk("b2b_first_valid", int'(valid4), 1);
    cnt = 0;
    while (valid4 && cnt < 100) begin cnt++; @(negedge clk); end
    chk("b2b_run_len", cnt, 24);
    chk("b2b_done", int'(done4), 1);
    chk("b2b_gap_valid", int'(valid4), 0);
    @(negedge clk);
    s = sample(1'b0);
    chk("b2b_rearm_valid", int'(s.valid), 1);
    chk("b2b_rearm_up", s.up, 0);
    chk("b2b_rearm_dn", s.dn, 8);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    cnt = 0;
    while (!done4 && cnt < 100) begin @(negedge clk); cnt++; end
    chk("b2b_second_len", cnt, 24);
    @(negedge clk);

    run(1'b1, 1'b0, 1'b0, 300, 1'b0);
    run(1'b1, 1'b0, 1'b0, 0, 1'b0); check_seq("n8_after_rst", 8, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
